nf10_axis_width_downconverter: RTL and testbench

- AXI4-Stream width down-converter. Splits each 256-bit slave beat into up to four 64-bit master beats, in order from LSB to MSB.
- Sits on the transmit side of the 256-bit core datapath and feeds the 64-bit 10G MAC interfaces. It is the counterpart of the existing 64-to-256 up-converter.
- Carries the NetFPGA 128-bit tuser metadata (len/spt/dpt) through with each packet.

---
 rtl/nf10_axis_width_downconverter.sv | 150 +++++++++++++++
 tb/tb_nf10_axis_width_downconverter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_axis_width_downconverter.sv
// nf10_axis_width_downconverter
//   AXI4-Stream 256-to-64 width down-converter for the transmit path between
//   the 256-bit core datapath and the 64-bit 10G MAC interfaces. Each slave
//   beat is buffered and emitted as up to four master beats, lane 0 (LSB)
//   first. NetFPGA tuser metadata (len/spt/dpt) travels with each packet.
//
// Ports
//   axi_aclk, axi_resetn     clock, synchronous active-low reset
//   s_axis_t{data,strb,user,valid,last}, s_axis_tready   256-bit slave side
//   m_axis_t{data,strb,user,valid,last}, m_axis_tready   64-bit master side
//
// Build option
//   NF10_AXIS_DOWNCONV_TUSER_HOLD_EN: when defined, the packet's tuser is
//   driven on every output beat of the packet instead of only the first.
module nf10_axis_width_downconverter #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_DATA_WIDTH  = 64,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
   input  logic                              axi_aclk,
   input  logic                              axi_resetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast
);

   localparam int M_STRB_W = C_M_AXIS_DATA_WIDTH / 8;
   localparam int S_STRB_W = C_S_AXIS_DATA_WIDTH / 8;

   typedef enum logic {EMPTY, DRAIN} state_t;

   state_t                            state_q, state_d;
   logic [C_S_AXIS_DATA_WIDTH-1:0]    data_q,  data_d;
   logic [S_STRB_W-1:0]               strb_q,  strb_d;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]   user_q,  user_d;
   logic                              last_q,  last_d;
   logic [1:0]                        lane_q,  lane_d;
   logic [1:0]                        final_q, final_d;
   logic                              sof_q,   sof_d;    // next output beat starts a packet
   logic                              in_sof_q, in_sof_d; // next input beat starts a packet

   logic       at_final;
   logic       accept;
   logic       m_hs;
   logic [1:0] s_final;

   // Highest lane holding valid bytes; strobes are contiguous from bit 0 on a
   // last beat, so this is where the packet ends. Non-last beats are full.
   always_comb begin
      s_final = 2'd3;
      if (s_axis_tlast) begin
         s_final = '0;
         for (int unsigned l = 0; l < 4; l++) begin
            if (|s_axis_tstrb[l*M_STRB_W +: M_STRB_W]) s_final = 2'(l);
         end
      end
   end

   assign at_final = (lane_q == final_q);

   // Accept a new slave beat in the same cycle the last lane of the current
   // beat is handed off, so back-to-back beats stream without bubbles.
   assign s_axis_tready = axi_resetn &&
                          ((state_q == EMPTY) ||
                           ((state_q == DRAIN) && at_final && m_axis_tready));
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign m_hs          = (state_q == DRAIN) && m_axis_tready;

   always_comb begin
      m_axis_tvalid = (state_q == DRAIN);
      m_axis_tdata  = '0;
      m_axis_tstrb  = '0;
      m_axis_tuser  = '0;
      m_axis_tlast  = 1'b0;
      if (state_q == DRAIN) begin
         m_axis_tdata = data_q[32'(lane_q)*C_M_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH];
         m_axis_tstrb = strb_q[32'(lane_q)*M_STRB_W +: M_STRB_W];
         m_axis_tlast = last_q && at_final;
`ifdef NF10_AXIS_DOWNCONV_TUSER_HOLD_EN
         m_axis_tuser = user_q;
`else
         if (sof_q) m_axis_tuser = user_q;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      strb_d   = strb_q;
      user_d   = user_q;
      last_d   = last_q;
      lane_d   = lane_q;
      final_d  = final_q;
      sof_d    = sof_q;
      in_sof_d = in_sof_q;

      if (m_hs) sof_d = m_axis_tlast;

      if (accept) begin
         // Covers both the EMPTY load and the DRAIN final-lane reload.
         state_d  = DRAIN;
         data_d   = s_axis_tdata;
         strb_d   = s_axis_tstrb;
         last_d   = s_axis_tlast;
         final_d  = s_final;
         lane_d   = '0;
         in_sof_d = s_axis_tlast;
         if (in_sof_q) user_d = s_axis_tuser;
      end else if (m_hs) begin
         if (at_final) state_d = EMPTY;
         else          lane_d  = lane_q + 2'd1;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         state_q  <= EMPTY;
         data_q   <= '0;
         strb_q   <= '0;
         user_q   <= '0;
         last_q   <= 1'b0;
         lane_q   <= '0;
         final_q  <= '0;
         sof_q    <= 1'b1;
         in_sof_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         strb_q   <= strb_d;
         user_q   <= user_d;
         last_q   <= last_d;
         lane_q   <= lane_d;
         final_q  <= final_d;
         sof_q    <= sof_d;
         in_sof_q <= in_sof_d;
      end
   end

endmodule

// File: tb/tb_nf10_axis_width_downconverter.sv
module tb_nf10_axis_width_downconverter;

   logic           axi_aclk = 1'b0;
   logic           axi_resetn;
   logic [255:0]   s_axis_tdata;
   logic [31:0]    s_axis_tstrb;
   logic [127:0]   s_axis_tuser;
   logic           s_axis_tvalid;
   logic           s_axis_tready;
   logic           s_axis_tlast;
   logic [63:0]    m_axis_tdata;
   logic [7:0]     m_axis_tstrb;
   logic [127:0]   m_axis_tuser;
   logic           m_axis_tvalid;
   logic           m_axis_tready;
   logic           m_axis_tlast;

   typedef struct packed {
      logic [63:0]  data;
      logic [7:0]   strb;
      logic [127:0] user;
      logic         last;
   } beat_t;

   beat_t exp_q[$];
   beat_t mon_q[$];
   int    mon_cyc[$];

   int    checks    = 0;
   int    failures  = 0;
   int    stall_err = 0;
   int    rdy_err   = 0;
   int    cyc       = 0;
   int    out_idx   = 0;
   bit    prev_stall = 0;
   beat_t prev_beat;
   bit    rdy_rand  = 0;

   nf10_axis_width_downconverter #(
      .C_S_AXIS_DATA_WIDTH  (256),
      .C_M_AXIS_DATA_WIDTH  (64),
      .C_S_AXIS_TUSER_WIDTH (128),
      .C_M_AXIS_TUSER_WIDTH (128)
   ) dut (
      .axi_aclk      (axi_aclk),
      .axi_resetn    (axi_resetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
   );

   always #5 axi_aclk = ~axi_aclk;

   // Mid-cycle observer: logs output handshakes, flags output changes during
   // stalls and slave-ready values that disagree with the lane position.
   always @(negedge axi_aclk) begin
      cyc <= cyc + 1;
      if (!axi_resetn) begin
         out_idx    <= 0;
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && (!m_axis_tvalid ||
             ({m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} !== prev_beat)))
            stall_err <= stall_err + 1;
         if (s_axis_tready !== (m_axis_tvalid ?
               (m_axis_tready && (m_axis_tlast || (out_idx % 4) == 3)) : 1'b1))
            rdy_err <= rdy_err + 1;
         if (m_axis_tvalid && m_axis_tready) begin
            mon_q.push_back({m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast});
            mon_cyc.push_back(cyc);
            out_idx <= m_axis_tlast ? 0 : out_idx + 1;
         end
         prev_stall <= m_axis_tvalid && !m_axis_tready;
         prev_beat  <= {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] bval(int idx, int id);
      return 8'(idx + id * 13);
   endfunction

   task automatic step();
      @(posedge axi_aclk);
      #1;
      if (rdy_rand) m_axis_tready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic drive_beat(input logic [255:0] d, input logic [31:0] s,
                             input logic [127:0] u, input logic l);
      bit done = 1'b0;
      s_axis_tdata  = d;
      s_axis_tstrb  = s;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      for (int n = 0; n < 2000 && !done; n++) begin
         @(negedge axi_aclk);
         done = s_axis_tready;
         step();
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL drive_beat_timeout got=no_accept exp=accept");
      end
   endtask

   task automatic end_input();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tstrb  = '0;
      s_axis_tuser  = '0;
   endtask

   // Builds the packet bytes, queues the expected 64-bit beats, drives it.
   task automatic send_packet(input int len, input logic [127:0] user, input int id);
      int            nb;
      int            fin;
      logic [255:0]  d;
      logic [31:0]   s;
      logic          l;
      beat_t         e;
      nb = (len + 31) / 32;
      for (int j = 0; j < nb; j++) begin
         d = '0;
         s = '0;
         for (int k = 0; k < 32; k++) begin
            if (32 * j + k < len) begin
               d[8*k +: 8] = bval(32 * j + k, id);
               s[k] = 1'b1;
            end
         end
         l = (j == nb - 1);
         fin = 0;
         for (int ln = 0; ln < 4; ln++) if (|s[8*ln +: 8]) fin = ln;
         for (int ln = 0; ln <= fin; ln++) begin
            e.data = d[64*ln +: 64];
            e.strb = s[8*ln +: 8];
            e.last = l && (ln == fin);
`ifdef NF10_AXIS_DOWNCONV_TUSER_HOLD_EN
            e.user = user;
`else
            e.user = (j == 0 && ln == 0) ? user : '0;
`endif
            exp_q.push_back(e);
         end
         drive_beat(d, s, (j == 0) ? user : ~user, l);
      end
   endtask

   task automatic wait_out(input int n);
      for (int c = 0; c < 20000 && mon_q.size() < n; c++) step();
   endtask

   task automatic compare_q(input string name);
      int n;
      wait_out(exp_q.size());
      repeat (3) step();
      checks++;
      if (mon_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL %s beat_count got=%0d exp=%0d", name, mon_q.size(), exp_q.size());
      end
      n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (mon_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL %s beat %0d got d=%h s=%h u=%h l=%b exp d=%h s=%h u=%h l=%b",
                     name, i, mon_q[i].data, mon_q[i].strb, mon_q[i].user, mon_q[i].last,
                     exp_q[i].data, exp_q[i].strb, exp_q[i].user, exp_q[i].last);
         end
      end
      mon_q.delete();
      mon_cyc.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      axi_resetn    = 1'b0;
      m_axis_tready = 1'b1;
      end_input();
      repeat (3) step();
      @(negedge axi_aclk);
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
      checks++; if (m_axis_tlast  !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", m_axis_tlast); end
      checks++; if (m_axis_tdata  !== '0)   begin failures++; $display("FAIL rst_tdata got=%h exp=0", m_axis_tdata); end
      checks++; if (m_axis_tstrb  !== '0)   begin failures++; $display("FAIL rst_tstrb got=%h exp=0", m_axis_tstrb); end
      checks++; if (m_axis_tuser  !== '0)   begin failures++; $display("FAIL rst_tuser got=%h exp=0", m_axis_tuser); end
      checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL rst_sready got=%b exp=0", s_axis_tready); end
      step();
      axi_resetn = 1'b1;
      @(negedge axi_aclk);
      checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL rel_sready got=%b exp=1", s_axis_tready); end
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rel_tvalid got=%b exp=0", m_axis_tvalid); end
      step();
   endtask

   task automatic test_64b();
      logic [127:0] u = 128'h0000_0000_0000_0000_0000_0000_0040_0104;
      send_packet(64, u, 0);
      end_input();
      wait_out(8);
      checks++; if (mon_q[0].user !== u) begin failures++; $display("FAIL p64_user0 got=%h exp=%h", mon_q[0].user, u); end
`ifdef NF10_AXIS_DOWNCONV_TUSER_HOLD_EN
      checks++; if (mon_q[7].user !== u) begin failures++; $display("FAIL p64_user7 got=%h exp=%h", mon_q[7].user, u); end
`else
      checks++; if (mon_q[1].user !== '0) begin failures++; $display("FAIL p64_user1 got=%h exp=0", mon_q[1].user); end
`endif
      checks++; if (mon_q[1].data !== 64'h0f0e0d0c0b0a0908) begin failures++; $display("FAIL p64_data1 got=%h exp=0f0e0d0c0b0a0908", mon_q[1].data); end
      checks++; if (mon_q[6].last !== 1'b0) begin failures++; $display("FAIL p64_last6 got=%b exp=0", mon_q[6].last); end
      checks++; if (mon_q[7].last !== 1'b1) begin failures++; $display("FAIL p64_last7 got=%b exp=1", mon_q[7].last); end
      compare_q("p64");
   endtask

   task automatic test_70b();
      send_packet(70, 128'h0000_0000_0000_0000_0000_0000_0046_0201, 0);
      end_input();
      wait_out(9);
      checks++; if (mon_q[8].strb !== 8'h3f) begin failures++; $display("FAIL p70_strb8 got=%h exp=3f", mon_q[8].strb); end
      checks++; if (mon_q[8].data !== 64'h0000454443424140) begin failures++; $display("FAIL p70_data8 got=%h exp=0000454443424140", mon_q[8].data); end
      checks++; if (mon_q[8].last !== 1'b1) begin failures++; $display("FAIL p70_last8 got=%b exp=1", mon_q[8].last); end
      checks++; if (mon_q[7].last !== 1'b0) begin failures++; $display("FAIL p70_last7 got=%b exp=0", mon_q[7].last); end
      compare_q("p70");
   endtask

   task automatic test_back_to_back();
      logic [127:0] u2 = 128'h0000_0000_0000_0000_0000_0000_0040_0810;
      send_packet(24, 128'h0000_0000_0000_0000_0000_0000_0018_0402, 1);
      send_packet(64, u2, 2);
      end_input();
      wait_out(11);
      checks++; if (mon_q[0].strb !== 8'hff) begin failures++; $display("FAIL b2b_strb0 got=%h exp=ff", mon_q[0].strb); end
      checks++; if (mon_q[2].strb !== 8'hff) begin failures++; $display("FAIL b2b_strb2 got=%h exp=ff", mon_q[2].strb); end
      checks++; if (mon_q[1].last !== 1'b0)  begin failures++; $display("FAIL b2b_last1 got=%b exp=0", mon_q[1].last); end
      checks++; if (mon_q[2].last !== 1'b1)  begin failures++; $display("FAIL b2b_last2 got=%b exp=1", mon_q[2].last); end
      checks++; if (mon_q[3].user !== u2)    begin failures++; $display("FAIL b2b_user3 got=%h exp=%h", mon_q[3].user, u2); end
      for (int i = 1; i < 11; i++) begin
         checks++;
         if (mon_cyc[i] - mon_cyc[i-1] != 1) begin
            failures++;
            $display("FAIL b2b_gap beat %0d got=%0d exp=1", i, mon_cyc[i] - mon_cyc[i-1]);
         end
      end
      compare_q("b2b");
   endtask

   task automatic test_reset_mid();
      logic [127:0] ub = 128'h0000_0000_0000_0000_0000_0000_0020_0301;
      m_axis_tready = 1'b0;
      drive_beat({4{64'h1111_2222_3333_4444}}, '1, 128'h0000_0000_0000_0000_0000_0000_0040_0a0a, 1'b0);
      end_input();
      m_axis_tready = 1'b1;
      step();
      m_axis_tready = 1'b0;
      @(negedge axi_aclk);
      checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL mid_pre_tvalid got=%b exp=1", m_axis_tvalid); end
      axi_resetn = 1'b0;
      step();
      axi_resetn = 1'b1;
      @(negedge axi_aclk);
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid got=%b exp=0", m_axis_tvalid); end
      checks++; if (m_axis_tlast  !== 1'b0) begin failures++; $display("FAIL mid_tlast got=%b exp=0", m_axis_tlast); end
      checks++; if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL mid_sready got=%b exp=1", s_axis_tready); end
      mon_q.delete();
      mon_cyc.delete();
      exp_q.delete();
      m_axis_tready = 1'b1;
      step();
      send_packet(32, ub, 4);
      end_input();
      wait_out(4);
      checks++; if (mon_q[0].user !== ub)  begin failures++; $display("FAIL mid_user0 got=%h exp=%h", mon_q[0].user, ub); end
      checks++; if (mon_q[3].last !== 1'b1) begin failures++; $display("FAIL mid_last3 got=%b exp=1", mon_q[3].last); end
      compare_q("mid_reset");
   endtask

   task automatic test_random();
      rdy_rand = 1'b1;
      for (int p = 0; p < 100; p++) begin
         send_packet($urandom_range(64, 1518), {$urandom, $urandom, $urandom, $urandom}, 10 + p);
      end
      end_input();
      compare_q("random");
      rdy_rand      = 1'b0;
      m_axis_tready = 1'b1;
      step();
      checks++; if (stall_err != 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stall_err); end
      checks++; if (rdy_err != 0)   begin failures++; $display("FAIL sready_lane got=%0d exp=0", rdy_err); end
   endtask

   initial begin
      test_reset();
      test_64b();
      test_70b();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
